sm83_cb_exec: RTL and testbench
===============================

# sm83_cb_exec

Multi-cycle sequencer for the SM83 CB-prefixed instruction space (rotate/shift/SWAP/BIT/RES/SET). It sits between the instruction fetch/decode front end and the `alu` datapath. It decodes the CB opcode byte into an `alu_op_t`, sources the operand from the register file or from memory at (HL), and drives the ALU. It then merges ALU flags into F per instruction class and writes the result back.

## Interface
No parameters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; `cb_opcode` is valid in the same cycle.
- `cb_opcode` in 8: byte following the 0xCB prefix.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `reg_rd_sel` out 3: register index (0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 7 A); combinational read.
- `reg_rd_data` in `data_t`: selected register value.
- `reg_wr_en` out 1; `reg_wr_sel` out 3; `reg_wr_data` out `data_t`: register writeback.
- `flags_in` in `flags_t`: current F.
- `flags_wr_en` out 1; `flags_out` out `flags_t`: F writeback.
- `hl` in 16: current HL.
- `alu_op` out `alu_op_t`; `alu_op1` out `data_t`; `alu_op2` out `data_t` (always 0); `alu_in_flags` out `flags_t` (= `flags_in`).
- `alu_result` in `data_t`; `alu_flags` in `flags_t`: ALU response, combinational.
- `mem_addr` out 16: equals latched HL during memory states, else 0.
- `mem_rd_req` out 1; `mem_rd_valid` in 1; `mem_rd_data` in `data_t`: read handshake.
- `mem_wr_req` out 1; `mem_wr_data` out `data_t`; `mem_wr_ack` in 1: write handshake.

## Operation
- Decode by `cb_opcode[7:6]`:
  - 00: shift group selected by [5:3] (0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL).
  - 01: ALU_BIT_b. 10: ALU_RES_b. 11: ALU_SET_b. Here b = [5:3].
  - Operand from [2:0]; the value 6 selects (HL).
- On `start` in IDLE: latch the opcode, decoded op, register index and `hl`.
- `start` is ignored when not IDLE.
- States:
  - IDLE: `alu_op` = ALU_NOP; all strobes low.
  - EXEC (register operand): `alu_op1` = `reg_rd_data`; write `alu_result` to the same register (not for BIT); write flags; `done`; next state IDLE.
  - MEM_RD: hold `mem_rd_req` until `mem_rd_valid` is sampled high; capture `mem_rd_data`; go to MEM_EXEC.
  - MEM_EXEC: `alu_op1` = captured byte; write flags.
    - BIT: `done`, then IDLE.
    - Otherwise: register `alu_result` into `mem_wr_data`, then go to MEM_WR.
  - MEM_WR: hold `mem_wr_req` with stable `mem_wr_data` until `mem_wr_ack` is sampled high; assert `done` in the ack cycle, then IDLE.
- Flag merge on `flags_out`:
  - Shift group: Z = `alu_flags.z`, N = 0, H = 0, C = `alu_flags.c`.
  - BIT: Z = `alu_flags.z`, N = 0, H = 1, C = `flags_in.c` (preserved).
  - RES/SET: `flags_wr_en` is never asserted.
- `busy` is high in every non-IDLE state, including the `done` cycle.

## Timing
- Reset values:
  - `busy`, `done`, `reg_wr_en`, `flags_wr_en`, `mem_rd_req` and `mem_wr_req` are 0.
  - `alu_op` is ALU_NOP.
  - `mem_wr_data`, `reg_wr_data`, `mem_addr` and `flags_out` are 0.
  - State is IDLE.
- Register operand: `start` at cycle N leads to EXEC at N+1, with `reg_wr_en`, `flags_wr_en` and `done` all in N+1. Back-to-back `start` is accepted at N+2.
- (HL) operand:
  - MEM_RD is entered at N+1.
  - With zero wait (valid high at N+1): MEM_EXEC at N+2, MEM_WR from N+3, `done` no earlier than N+3.
  - BIT (HL) has `done` at N+2.
  - Each extra wait cycle on read or write adds one cycle.
- Requests are level signals held until handshake. The data captured is `mem_rd_data` in the cycle where `mem_rd_valid` is high.
- `mem_rd_valid`/`mem_wr_ack` outside the matching state: ignored.
- `rst_n` low in any state: IDLE at the next edge; pending requests drop; no writeback; no `done`.

## Test plan
- RLC B (0x00), B=0x85, F=0x00: the cycle after `start` gives `reg_wr_sel`=0, `reg_wr_data`=0x0B, `flags_out` Z0 N0 H0 C1, `done`=1. `busy` is low the next cycle.
- BIT 7,A (0x7F), A=0x7F, F.c=1: `flags_out` Z1 N0 H1 C1; `reg_wr_en` stays 0; `done` at N+1.
- SWAP (HL) (0x36), `hl`=0xC000, read returns 0xF0 after 3 wait cycles:
  - `mem_addr`=0xC000 throughout.
  - Write of 0x0F; flags Z0 N0 H0 C0.
  - With ack after 2 waits, `done` comes in the ack cycle.
- RES 0,(HL) (0x86), memory 0xFF: write 0xFE; `flags_wr_en` never asserted. SET 3,C (0xD9), C=0x00: C becomes 0x08 with no flag write.
- SRA L (0x2D), L=0x81: result 0xC0, C1 Z0. SRL E (0x3B), E=0x01: result 0x00, Z1 C1.
- `start` pulsed during MEM_RD is ignored. `rst_n` low during MEM_RD wait: next cycle `mem_rd_req`=0, `busy`=0; no `done`/writes. A fresh `start` after reset completes normally.

Source files
------------

// File: rtl/sm83_cb_exec.sv
// SM83 CB-prefix sequencer: decodes the opcode, sources the operand from a
// register or (HL), drives the external ALU and writes result and flags back.
`timescale 1ns/1ps
package sm83_pkg;
    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic       z;
        logic       n;
        logic       h;
        logic       c;
        logic [3:0] rsvd;
    } flags_t;

    typedef enum logic [5:0] {
        ALU_NOP   = 6'd0,
        ALU_RLC   = 6'd8, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SWAP, ALU_SRL,
        ALU_BIT_0, ALU_BIT_1, ALU_BIT_2, ALU_BIT_3, ALU_BIT_4, ALU_BIT_5, ALU_BIT_6, ALU_BIT_7,
        ALU_RES_0, ALU_RES_1, ALU_RES_2, ALU_RES_3, ALU_RES_4, ALU_RES_5, ALU_RES_6, ALU_RES_7,
        ALU_SET_0, ALU_SET_1, ALU_SET_2, ALU_SET_3, ALU_SET_4, ALU_SET_5, ALU_SET_6, ALU_SET_7
    } alu_op_t;
endpackage

module sm83_cb_exec
    import sm83_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  cb_opcode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  reg_rd_sel_o,
    input  data_t       reg_rd_data_i,
    output logic        reg_wr_en_o,
    output logic [2:0]  reg_wr_sel_o,
    output data_t       reg_wr_data_o,
    input  flags_t      flags_in_i,
    output logic        flags_wr_en_o,
    output flags_t      flags_out_o,
    input  logic [15:0] hl_i,
    output alu_op_t     alu_op_o,
    output data_t       alu_op1_o,
    output data_t       alu_op2_o,
    output flags_t      alu_in_flags_o,
    input  data_t       alu_result_i,
    input  flags_t      alu_flags_i,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_req_o,
    input  logic        mem_rd_valid_i,
    input  data_t       mem_rd_data_i,
    output logic        mem_wr_req_o,
    output data_t       mem_wr_data_o,
    input  logic        mem_wr_ack_i
);
    localparam int unsigned ADDR_W  = 16;
    localparam logic [1:0]  CLS_BIT = 2'b01;
    localparam logic [2:0]  SEL_HL  = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_RD, S_MEM_EXEC, S_MEM_WR} state_t;

    state_t              state_q, state_d;
    alu_op_t             op_q, op_d;
    logic [1:0]          cls_q, cls_d;
    logic [2:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   hl_q, hl_d;
    data_t               rd_data_q, rd_data_d;
    data_t               wr_data_q, wr_data_d;

    logic   is_bit;
    logic   wr_flags;
    flags_t merged_flags;
    logic   unused_alu_bits;

    assign is_bit          = (cls_q == CLS_BIT);
    assign wr_flags        = ~cls_q[1];
    assign unused_alu_bits = ^{alu_flags_i.n, alu_flags_i.h, alu_flags_i.rsvd};

    // BIT keeps the incoming carry and forces H; shifts take Z/C from the ALU
    always_comb begin
        merged_flags      = '0;
        merged_flags.z    = alu_flags_i.z;
        merged_flags.h    = is_bit;
        merged_flags.c    = is_bit ? flags_in_i.c : alu_flags_i.c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= ALU_NOP;
            cls_q     <= '0;
            sel_q     <= '0;
            hl_q      <= '0;
            rd_data_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cls_q     <= cls_d;
            sel_q     <= sel_d;
            hl_q      <= hl_d;
            rd_data_q <= rd_data_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cls_d     = cls_q;
        sel_d     = sel_q;
        hl_d      = hl_q;
        rd_data_d = rd_data_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // class 0..3 maps onto the shift/BIT/RES/SET blocks of the op encoding
                    op_d    = alu_op_t'({3'(cb_opcode_i[7:6]) + 3'd1, cb_opcode_i[5:3]});
                    cls_d   = cb_opcode_i[7:6];
                    sel_d   = cb_opcode_i[2:0];
                    hl_d    = hl_i;
                    state_d = (cb_opcode_i[2:0] == SEL_HL) ? S_MEM_RD : S_EXEC;
                end
            end
            S_EXEC: state_d = S_IDLE;
            S_MEM_RD: begin
                if (mem_rd_valid_i) begin
                    rd_data_d = mem_rd_data_i;
                    state_d   = S_MEM_EXEC;
                end
            end
            S_MEM_EXEC: begin
                if (is_bit) begin
                    state_d = S_IDLE;
                end else begin
                    wr_data_d = alu_result_i;
                    state_d   = S_MEM_WR;
                end
            end
            S_MEM_WR: if (mem_wr_ack_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = 1'b0;
        reg_wr_en_o   = 1'b0;
        reg_wr_sel_o  = sel_q;
        reg_wr_data_o = '0;
        flags_wr_en_o = 1'b0;
        flags_out_o   = '0;
        alu_op_o      = ALU_NOP;
        alu_op1_o     = '0;
        mem_addr_o    = '0;
        mem_rd_req_o  = 1'b0;
        mem_wr_req_o  = 1'b0;
        case (state_q)
            S_EXEC: begin
                alu_op_o      = op_q;
                alu_op1_o     = reg_rd_data_i;
                reg_wr_en_o   = ~is_bit;
                reg_wr_data_o = is_bit ? data_t'(0) : alu_result_i;
                flags_wr_en_o = wr_flags;
                flags_out_o   = wr_flags ? merged_flags : flags_t'(0);
                done_o        = 1'b1;
            end
            S_MEM_RD: begin
                mem_addr_o   = hl_q;
                mem_rd_req_o = 1'b1;
            end
            S_MEM_EXEC: begin
                mem_addr_o    = hl_q;
                alu_op_o      = op_q;
                alu_op1_o     = rd_data_q;
                flags_wr_en_o = wr_flags;
                flags_out_o   = wr_flags ? merged_flags : flags_t'(0);
                done_o        = is_bit;
            end
            S_MEM_WR: begin
                mem_addr_o   = hl_q;
                mem_wr_req_o = 1'b1;
                done_o       = mem_wr_ack_i;
            end
            default: ;
        endcase
    end

    assign reg_rd_sel_o   = sel_q;
    assign alu_op2_o      = '0;
    assign alu_in_flags_o = flags_in_i;
    assign mem_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_sm83_cb_exec.sv
// Directed bench for sm83_cb_exec with a behavioural ALU and register file.
`timescale 1ns/1ps
module tb_sm83_cb_exec;
    import sm83_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cb_opcode;
    logic        busy, done;
    logic [2:0]  reg_rd_sel;
    data_t       reg_rd_data;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_sel;
    data_t       reg_wr_data;
    flags_t      flags_in;
    logic        flags_wr_en;
    flags_t      flags_out;
    logic [15:0] hl;
    alu_op_t     alu_op;
    data_t       alu_op1, alu_op2;
    flags_t      alu_in_flags;
    data_t       alu_result;
    flags_t      alu_flags;
    logic [15:0] mem_addr;
    logic        mem_rd_req, mem_rd_valid;
    data_t       mem_rd_data;
    logic        mem_wr_req;
    data_t       mem_wr_data;
    logic        mem_wr_ack;

    logic [7:0]  regs [8];
    logic [2:0]  bit_idx;
    logic        bit_op;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    sm83_cb_exec dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cb_opcode_i(cb_opcode),
        .busy_o(busy), .done_o(done),
        .reg_rd_sel_o(reg_rd_sel), .reg_rd_data_i(reg_rd_data),
        .reg_wr_en_o(reg_wr_en), .reg_wr_sel_o(reg_wr_sel), .reg_wr_data_o(reg_wr_data),
        .flags_in_i(flags_in), .flags_wr_en_o(flags_wr_en), .flags_out_o(flags_out),
        .hl_i(hl), .alu_op_o(alu_op), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
        .alu_in_flags_o(alu_in_flags), .alu_result_i(alu_result), .alu_flags_i(alu_flags),
        .mem_addr_o(mem_addr), .mem_rd_req_o(mem_rd_req), .mem_rd_valid_i(mem_rd_valid),
        .mem_rd_data_i(mem_rd_data), .mem_wr_req_o(mem_wr_req), .mem_wr_data_o(mem_wr_data),
        .mem_wr_ack_i(mem_wr_ack)
    );

    assign reg_rd_data = regs[reg_rd_sel];

    // Reference ALU; N/H/rsvd and the BIT carry are deliberately noisy so the merge is exercised
    always_comb begin
        alu_result = alu_op1;
        alu_flags  = flags_t'(8'h6F);
        bit_idx    = 3'd0;
        bit_op     = 1'b0;
        case (alu_op)
            ALU_RLC:  begin alu_result = {alu_op1[6:0], alu_op1[7]};       alu_flags.c = alu_op1[7]; end
            ALU_RRC:  begin alu_result = {alu_op1[0], alu_op1[7:1]};       alu_flags.c = alu_op1[0]; end
            ALU_RL:   begin alu_result = {alu_op1[6:0], alu_in_flags.c};   alu_flags.c = alu_op1[7]; end
            ALU_RR:   begin alu_result = {alu_in_flags.c, alu_op1[7:1]};   alu_flags.c = alu_op1[0]; end
            ALU_SLA:  begin alu_result = {alu_op1[6:0], 1'b0};             alu_flags.c = alu_op1[7]; end
            ALU_SRA:  begin alu_result = {alu_op1[7], alu_op1[7:1]};       alu_flags.c = alu_op1[0]; end
            ALU_SWAP: begin alu_result = {alu_op1[3:0], alu_op1[7:4]};     alu_flags.c = 1'b0;       end
            ALU_SRL:  begin alu_result = {1'b0, alu_op1[7:1]};             alu_flags.c = alu_op1[0]; end
            default: begin
                if (alu_op >= ALU_BIT_0 && alu_op <= ALU_BIT_7) begin
                    bit_idx     = 3'(alu_op - ALU_BIT_0);
                    bit_op      = 1'b1;
                    alu_flags.c = ~alu_in_flags.c;
                    alu_flags.h = 1'b0;
                end else if (alu_op >= ALU_RES_0 && alu_op <= ALU_RES_7) begin
                    bit_idx    = 3'(alu_op - ALU_RES_0);
                    alu_result = alu_op1 & ~(8'd1 << bit_idx);
                end else if (alu_op >= ALU_SET_0 && alu_op <= ALU_SET_7) begin
                    bit_idx    = 3'(alu_op - ALU_SET_0);
                    alu_result = alu_op1 | (8'd1 << bit_idx);
                end
            end
        endcase
        alu_flags.z = bit_op ? ~alu_op1[bit_idx] : (alu_result == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start in the current cycle; returns settled inside cycle N+1
    task automatic issue(input logic [7:0] op);
        start     = 1'b1;
        cb_opcode = op;
        tick();
        start     = 1'b0;
        cb_opcode = 8'hFF;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cb_opcode = 8'h00; flags_in = '0; hl = 16'h0000;
        mem_rd_valid = 1'b0; mem_rd_data = 8'h00; mem_wr_ack = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        tick(); tick(); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_reg_wr_en", 32'(reg_wr_en), 0);
        chk("rst_flags_wr_en", 32'(flags_wr_en), 0);
        chk("rst_mem_rd_req", 32'(mem_rd_req), 0);
        chk("rst_mem_wr_req", 32'(mem_wr_req), 0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_NOP));
        chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
        chk("rst_reg_wr_data", 32'(reg_wr_data), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_flags_out", 32'(flags_out), 0);
        rst_n = 1'b1;
        tick();

        // RLC B: 0x85 -> 0x0B, C=1
        regs[0] = 8'h85; flags_in = flags_t'(8'h00);
        issue(8'h00);
        chk("rlc_alu_op", 32'(alu_op), 32'(ALU_RLC));
        chk("rlc_alu_op2", 32'(alu_op2), 0);
        chk("rlc_wr_en", 32'(reg_wr_en), 1);
        chk("rlc_wr_sel", 32'(reg_wr_sel), 0);
        chk("rlc_wr_data", 32'(reg_wr_data), 32'h0B);
        chk("rlc_flags_wr_en", 32'(flags_wr_en), 1);
        chk("rlc_flags", 32'(flags_out), 32'h10);
        chk("rlc_done", 32'(done), 1);
        chk("rlc_busy", 32'(busy), 1);
        tick();
        chk("rlc_busy_after", 32'(busy), 0);
        chk("rlc_done_after", 32'(done), 0);

        // BIT 7,A issued back-to-back at N+2: A=0x7F, F.c=1 -> Z1 N0 H1 C1
        regs[7] = 8'h7F; flags_in = flags_t'(8'h10);
        issue(8'h7F);
        chk("bit_alu_op", 32'(alu_op), 32'(ALU_BIT_7));
        chk("bit_flags", 32'(flags_out), 32'hB0);
        chk("bit_flags_wr_en", 32'(flags_wr_en), 1);
        chk("bit_reg_wr_en", 32'(reg_wr_en), 0);
        chk("bit_done", 32'(done), 1);
        tick();
        chk("bit_idle", 32'(busy), 0);

        // SWAP (HL): read 0xF0 after 3 waits, ack after 2 waits
        hl = 16'hC000; flags_in = flags_t'(8'h00);
        issue(8'h36);
        hl = 16'h1234;
        chk("swap_rd_req", 32'(mem_rd_req), 1);
        chk("swap_addr_rd", 32'(mem_addr), 32'hC000);
        tick();
        start = 1'b1; cb_opcode = 8'h00; mem_wr_ack = 1'b1;
        #1;
        chk("swap_rd_req_w1", 32'(mem_rd_req), 1);
        chk("swap_wr_req_w1", 32'(mem_wr_req), 0);
        tick();
        start = 1'b0; mem_wr_ack = 1'b0;
        #1;
        chk("swap_rd_req_w2", 32'(mem_rd_req), 1);
        chk("swap_done_w2", 32'(done), 0);
        tick();
        mem_rd_valid = 1'b1; mem_rd_data = 8'hF0;
        #1;
        chk("swap_rd_req_v", 32'(mem_rd_req), 1);
        chk("swap_addr_v", 32'(mem_addr), 32'hC000);
        tick();
        mem_rd_valid = 1'b0; mem_rd_data = 8'h55;
        #1;
        chk("swap_exec_op", 32'(alu_op), 32'(ALU_SWAP));
        chk("swap_exec_op1", 32'(alu_op1), 32'hF0);
        chk("swap_exec_flags_wr", 32'(flags_wr_en), 1);
        chk("swap_exec_flags", 32'(flags_out), 32'h00);
        chk("swap_exec_rd_req", 32'(mem_rd_req), 0);
        chk("swap_exec_done", 32'(done), 0);
        chk("swap_exec_addr", 32'(mem_addr), 32'hC000);
        for (int w = 0; w < 2; w++) begin
            tick(); #1;
            chk("swap_wr_req_wait", 32'(mem_wr_req), 1);
            chk("swap_wr_data_wait", 32'(mem_wr_data), 32'h0F);
            chk("swap_wr_done_wait", 32'(done), 0);
        end
        tick();
        mem_wr_ack = 1'b1;
        #1;
        chk("swap_ack_done", 32'(done), 1);
        chk("swap_ack_busy", 32'(busy), 1);
        chk("swap_ack_addr", 32'(mem_addr), 32'hC000);
        chk("swap_ack_data", 32'(mem_wr_data), 32'h0F);
        tick();
        mem_wr_ack = 1'b0;
        #1;
        chk("swap_end_busy", 32'(busy), 0);
        chk("swap_end_wr_req", 32'(mem_wr_req), 0);
        chk("swap_end_addr", 32'(mem_addr), 0);

        // RES 0,(HL): zero-wait read of 0xFF, write 0xFE, no flag writes
        hl = 16'hD123;
        issue(8'h86);
        mem_rd_valid = 1'b1; mem_rd_data = 8'hFF;
        #1;
        chk("res_rd_flags_wr", 32'(flags_wr_en), 0);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk("res_exec_op", 32'(alu_op), 32'(ALU_RES_0));
        chk("res_exec_flags_wr", 32'(flags_wr_en), 0);
        chk("res_exec_done", 32'(done), 0);
        tick();
        mem_wr_ack = 1'b1;
        #1;
        chk("res_wr_data", 32'(mem_wr_data), 32'hFE);
        chk("res_wr_addr", 32'(mem_addr), 32'hD123);
        chk("res_done_n3", 32'(done), 1);
        chk("res_wr_flags_wr", 32'(flags_wr_en), 0);
        tick();
        mem_wr_ack = 1'b0;
        #1;
        chk("res_idle", 32'(busy), 0);

        // BIT 0,(HL): memory 0x01, F=0 -> Z0 N0 H1 C0, done at N+2
        hl = 16'h8000; flags_in = flags_t'(8'h00);
        issue(8'h46);
        mem_rd_valid = 1'b1; mem_rd_data = 8'h01;
        #1;
        chk("bithl_done_n1", 32'(done), 0);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk("bithl_done_n2", 32'(done), 1);
        chk("bithl_flags", 32'(flags_out), 32'h20);
        tick(); #1;
        chk("bithl_idle", 32'(busy), 0);
        chk("bithl_no_wr", 32'(mem_wr_req), 0);

        // SET 3,C: 0x00 -> 0x08, no flag write
        regs[1] = 8'h00;
        issue(8'hD9);
        chk("set_wr_sel", 32'(reg_wr_sel), 1);
        chk("set_wr_data", 32'(reg_wr_data), 32'h08);
        chk("set_wr_en", 32'(reg_wr_en), 1);
        chk("set_flags_wr", 32'(flags_wr_en), 0);
        tick();

        // SRA L: 0x81 -> 0xC0, C1 Z0
        regs[5] = 8'h81;
        issue(8'h2D);
        chk("sra_wr_sel", 32'(reg_wr_sel), 5);
        chk("sra_wr_data", 32'(reg_wr_data), 32'hC0);
        chk("sra_flags", 32'(flags_out), 32'h10);
        tick();

        // SRL E: 0x01 -> 0x00, Z1 C1
        regs[3] = 8'h01;
        issue(8'h3B);
        chk("srl_wr_sel", 32'(reg_wr_sel), 3);
        chk("srl_wr_data", 32'(reg_wr_data), 32'h00);
        chk("srl_flags", 32'(flags_out), 32'h90);
        tick();

        // Reset during MEM_RD wait
        hl = 16'hBEEF;
        issue(8'h06);
        chk("rstrd_req", 32'(mem_rd_req), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 8'hAA;
        #1;
        chk("rstrd_rd_req", 32'(mem_rd_req), 0);
        chk("rstrd_busy", 32'(busy), 0);
        chk("rstrd_done", 32'(done), 0);
        chk("rstrd_reg_wr", 32'(reg_wr_en), 0);
        chk("rstrd_flags_wr", 32'(flags_wr_en), 0);
        chk("rstrd_mem_wr", 32'(mem_wr_req), 0);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk("rstrd_valid_ignored", 32'(busy), 0);

        // Fresh RL D after reset: D=0x80, C=0 -> 0x00, Z1 C1
        regs[2] = 8'h80; flags_in = flags_t'(8'h00);
        issue(8'h12);
        chk("rl_wr_sel", 32'(reg_wr_sel), 2);
        chk("rl_wr_data", 32'(reg_wr_data), 32'h00);
        chk("rl_flags", 32'(flags_out), 32'h90);
        chk("rl_done", 32'(done), 1);
        tick();
        chk("rl_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
